// File: rtl/drum_column_engine.sv
// One column of the drum-membrane finite-difference solver. Each time step
// walks the column bottom to top, producing one node's next displacement
// every four cycles from two dual-port block RAMs (current, previous).
module drum_column_engine #(
    parameter int W          = 18,
    parameter int ROWS       = 30,
    parameter int AW         = 5,
    parameter int TAP_ROW    = 15,
    parameter int PREV_SHIFT = 10,
    parameter int DAMP_SHIFT = 9,
    parameter int SATURATE   = 0
) (
    input  logic                 clk_50,
    input  logic                 reset,
    input  logic                 init_we,
    input  logic [AW-1:0]        init_addr,
    input  logic signed [W-1:0]  init_data,
    input  logic                 step_start,
    input  logic signed [W-1:0]  rho_eff,
    input  logic signed [W-1:0]  left_u,
    input  logic signed [W-1:0]  right_u,
    output logic signed [W-1:0]  cur_u,
    output logic                 busy,
    output logic                 step_done,
    output logic signed [W-1:0]  tap_u,
    output logic                 wr_valid,
    output logic [AW-1:0]        wr_row,
    output logic signed [W-1:0]  wr_data
);
    typedef enum logic [2:0] {IDLE, RD, WT, LD, WR, DONE} state_t;

    localparam int XW = W + 3;
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
    localparam logic [AW-1:0] TAP      = AW'(TAP_ROW);
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    state_t state, nstate;
    logic [AW-1:0] row, mem_addr;
    logic signed [W-1:0] bottom_reg, center_reg, down_reg, up_reg, prv_reg, tap_cap;
    logic signed [W-1:0] curr_mem [ROWS];
    logic signed [W-1:0] prev_mem [ROWS];
    logic signed [W-1:0] q_curr, q_prev;
    logic signed [W-1:0] center, down, sum, m, inter_w, next_w, next_s, next_val;
    logic signed [2*W-1:0] prod;
    logic signed [XW-1:0] inter_x, next_x;
    logic init_ok, step_go, last_row, mem_we;
    logic unused_prod;

    function automatic logic signed [XW-1:0] sx(input logic signed [W-1:0] v);
        return {{(XW-W){v[W-1]}}, v};
    endfunction

    // Host loads are only honoured in IDLE and only for rows that exist.
    assign init_ok  = init_we && ({1'b0, init_addr} < (AW+1)'(ROWS));
    assign step_go  = step_start && !init_we;
    assign last_row = (row == LAST_ROW);
    // Row 0's centre lives in bottom_reg since nothing below it prefetches it.
    assign center   = (row == '0) ? bottom_reg : center_reg;
    assign down     = (row == '0) ? '0 : down_reg;
    assign mem_we   = (state == WR) || ((state == IDLE) && init_ok);
    assign mem_addr = (state == WR) ? row : init_addr;

    // Stencil update; the wrap path stays at W bits, the clamp path widens by 3.
    always_comb begin
        sum     = left_u + right_u + up_reg + down - (center <<< 2);
        prod    = $signed({{W{sum[W-1]}}, sum}) * $signed({{W{rho_eff[W-1]}}, rho_eff});
        m       = {prod[2*W-1], prod[2*W-3:W-1]};
        inter_w = m + (center <<< 1) - prv_reg + (prv_reg >>> PREV_SHIFT);
        next_w  = inter_w - (inter_w >>> DAMP_SHIFT);
        inter_x = sx(m) + (sx(center) <<< 1) - sx(prv_reg) + sx(prv_reg >>> PREV_SHIFT);
        next_x  = inter_x - (inter_x >>> DAMP_SHIFT);
        if (next_x > sx(SMAX))      next_s = SMAX;
        else if (next_x < sx(SMIN)) next_s = SMIN;
        else                        next_s = next_x[W-1:0];
        next_val = (SATURATE != 0) ? next_s : next_w;
    end
    assign unused_prod = ^{prod[2*W-2], prod[W-2:0]};

    // Block RAMs: registered read, old data on read-during-write, never reset.
    always_ff @(posedge clk_50) begin
        if (mem_we) begin
            curr_mem[mem_addr] <= (state == WR) ? next_val : init_data;
            prev_mem[mem_addr] <= (state == WR) ? center   : init_data;
        end
        if (state == RD) begin
            if (!last_row) q_curr <= curr_mem[row + AW'(1)];
            q_prev <= prev_mem[row];
        end
    end

    // State register.
    always_ff @(posedge clk_50) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    // Next-state logic: four cycles per row, then one DONE cycle.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (step_go) nstate = RD;
            RD:      nstate = WT;
            WT:      nstate = LD;
            LD:      nstate = WR;
            WR:      nstate = last_row ? DONE : RD;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy      = (state != IDLE);
        step_done = (state == DONE);
        wr_valid  = (state == WR);
        wr_row    = (state == WR) ? row : '0;
        wr_data   = (state == WR) ? next_val : '0;
        cur_u     = center;
    end

    // Row walker and neighbour shift registers; tap_u is loaded on entry to DONE.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            row        <= '0;
            bottom_reg <= '0;
            center_reg <= '0;
            down_reg   <= '0;
            up_reg     <= '0;
            prv_reg    <= '0;
            tap_cap    <= '0;
            tap_u      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_ok && (init_addr == '0)) bottom_reg <= init_data;
                    if (step_go) row <= '0;
                end
                LD: begin
                    up_reg  <= last_row ? '0 : q_curr;
                    prv_reg <= q_prev;
                end
                WR: begin
                    if (row == '0) bottom_reg <= next_val;
                    if (row == TAP) tap_cap <= center;
                    if (!last_row) begin
                        down_reg   <= center;
                        center_reg <= up_reg;
                        row        <= row + AW'(1);
                    end else begin
                        tap_u <= (row == TAP) ? center : tap_cap;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_drum_column_engine.sv
// Bench for drum_column_engine: a 30-row wrapping column and a 4-row
// saturating column, both checked row by row against a node-level model.
module tb_drum_column_engine;
    localparam int W = 18;

    logic clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    logic reset = 1'b1;
    logic [W-1:0] init_data = '0, rho_eff = '0, left_u = '0, right_u = '0;
    logic init_we0 = 1'b0, step0 = 1'b0, init_we1 = 1'b0, step1 = 1'b0;
    logic [4:0] init_addr0 = '0;
    logic [1:0] init_addr1 = '0;
    logic [W-1:0] cur0, tap0, wdat0, cur1, tap1, wdat1;
    logic busy0, done0, wv0, busy1, done1, wv1;
    logic [4:0] wrow0;
    logic [1:0] wrow1;

    drum_column_engine #(.W(18), .ROWS(30), .AW(5), .TAP_ROW(15), .PREV_SHIFT(10),
                         .DAMP_SHIFT(9), .SATURATE(0)) d0 (
        .clk_50(clk_50), .reset(reset), .init_we(init_we0), .init_addr(init_addr0),
        .init_data(init_data), .step_start(step0), .rho_eff(rho_eff), .left_u(left_u),
        .right_u(right_u), .cur_u(cur0), .busy(busy0), .step_done(done0), .tap_u(tap0),
        .wr_valid(wv0), .wr_row(wrow0), .wr_data(wdat0));

    drum_column_engine #(.W(18), .ROWS(4), .AW(2), .TAP_ROW(1), .PREV_SHIFT(10),
                         .DAMP_SHIFT(9), .SATURATE(1)) d1 (
        .clk_50(clk_50), .reset(reset), .init_we(init_we1), .init_addr(init_addr1),
        .init_data(init_data), .step_start(step1), .rho_eff(rho_eff), .left_u(left_u),
        .right_u(right_u), .cur_u(cur1), .busy(busy1), .step_done(done1), .tap_u(tap1),
        .wr_valid(wv1), .wr_row(wrow1), .wr_data(wdat1));

    int errors = 0, checks = 0;

    // Reference state per column: node values, bottom register, tap.
    longint mc [2][30];
    longint mp [2][30];
    longint mb [2];
    longint mt [2];
    longint ec [30];
    longint en [30];
    longint vbuf [30];

    logic [W-1:0] o_cur, o_tap, o_wdat;
    logic o_busy, o_done, o_wv;
    int o_row;

    function automatic int rows_of(input int s); return (s == 0) ? 30 : 4; endfunction
    function automatic int tap_of(input int s);  return (s == 0) ? 15 : 1;  endfunction

    function automatic longint wrapw(input longint x);
        longint md = longint'(1) << W;
        longint y = x & (md - 1);
        if (y >= (md >>> 1)) y = y - md;
        return y;
    endfunction

    function automatic longint clampw(input longint x);
        longint hi = (longint'(1) << (W-1)) - 1;
        longint lo = -(longint'(1) << (W-1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // One node update in plain integer arithmetic.
    function automatic longint node_next(input bit sat, input longint l, r, up, dn, c, p, rho);
        longint sum, prod, low, mm, inter;
        sum  = wrapw(l + r + up + dn - 4 * c);
        prod = sum * rho;
        low  = (prod >>> (W-1)) & ((longint'(1) << (W-1)) - 1);
        mm   = (prod < 0) ? low - (longint'(1) << (W-1)) : low;
        if (sat) begin
            inter = mm + 2 * c - p + (p >>> 10);
            return clampw(inter - (inter >>> 9));
        end
        inter = wrapw(mm + 2 * c - p + (p >>> 10));
        return wrapw(inter - (inter >>> 9));
    endfunction

    function automatic longint rnd_val();
        int k = int'($urandom_range(0, 3));
        case (k)
            0: return (longint'(1) << (W-1)) - 1;
            1: return -(longint'(1) << (W-1));
            2: return wrapw(longint'($urandom));
            default: return longint'($urandom_range(0, 2047)) - 1024;
        endcase
    endfunction

    task automatic model_plan(input int s, input longint rho, l, r);
        int rows = rows_of(s);
        for (int i = 0; i < rows; i++) ec[i] = (i == 0) ? mb[s] : mc[s][i];
        for (int i = 0; i < rows; i++)
            en[i] = node_next(s == 1, l, r, (i == rows-1) ? 0 : mc[s][i+1],
                              (i == 0) ? 0 : ec[i-1], ec[i], mp[s][i], rho);
    endtask

    task automatic model_commit(input int s, input int upto);
        for (int i = 0; i < upto; i++) begin
            mp[s][i] = ec[i];
            mc[s][i] = en[i];
        end
        if (upto > 0) mb[s] = en[0];
        if (upto == rows_of(s)) mt[s] = ec[tap_of(s)];
    endtask

    task automatic sample(input int s);
        if (s == 0) begin
            o_cur = cur0; o_tap = tap0; o_wdat = wdat0; o_busy = busy0;
            o_done = done0; o_wv = wv0; o_row = int'(wrow0);
        end else begin
            o_cur = cur1; o_tap = tap1; o_wdat = wdat1; o_busy = busy1;
            o_done = done1; o_wv = wv1; o_row = int'(wrow1);
        end
    endtask

    task automatic set_ctl(input int s, input logic st, input logic we, input int addr, input longint data);
        if (s == 0) begin step0 = st; init_we0 = we; init_addr0 = 5'(addr); end
        else        begin step1 = st; init_we1 = we; init_addr1 = 2'(addr); end
        init_data = W'(data);
    endtask

    // Back-to-back host writes of vbuf into every row; column 0 also gets an
    // out-of-range write that must be dropped.
    task automatic load_column(input int s);
        for (int a = 0; a < rows_of(s); a++) begin
            @(negedge clk_50);
            set_ctl(s, 1'b0, 1'b1, a, vbuf[a]);
            mc[s][a] = vbuf[a];
            mp[s][a] = vbuf[a];
            if (a == 0) mb[s] = vbuf[a];
        end
        if (s == 0) begin
            @(negedge clk_50);
            set_ctl(s, 1'b0, 1'b1, 31, 'h15555);
        end
        @(negedge clk_50);
        set_ctl(s, 1'b0, 1'b0, 0, 0);
    endtask

    // One full step, checked every cycle. glitch_at / abort_at (cycle offset
    // from the step_start edge, -1 = none) inject mid-step pulses or a reset.
    task automatic run_step(input int s, input longint rho, l, r, input int glitch_at, input int abort_at);
        int rows = rows_of(s);
        int last = 4 * rows + 1;
        int rr;
        logic exp_wv;
        model_plan(s, rho, l, r);
        rho_eff = W'(rho); left_u = W'(l); right_u = W'(r);
        @(negedge clk_50);
        sample(s);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_before_step dut%0d busy=%b required 0", s, o_busy); end
        set_ctl(s, 1'b1, 1'b0, 0, 0);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk_50);
            set_ctl(s, 1'b0, 1'b0, 0, 0);
            sample(s);
            checks++;
            if (o_busy !== 1'b1) begin errors++; $display("FAIL busy dut%0d cycle %0d got %b required 1", s, n, o_busy); end
            checks++;
            if (o_done !== (n == last)) begin errors++; $display("FAIL step_done dut%0d cycle %0d got %b required %b", s, n, o_done, n == last); end
            exp_wv = (n % 4 == 0) && (n <= 4 * rows);
            checks++;
            if (o_wv !== exp_wv) begin errors++; $display("FAIL wr_valid dut%0d cycle %0d got %b required %b", s, n, o_wv, exp_wv); end
            if (exp_wv) begin
                rr = n / 4 - 1;
                checks++;
                if (o_row !== rr || o_wdat !== W'(en[rr]) || o_cur !== W'(ec[rr])) begin
                    errors++;
                    $display("FAIL wr dut%0d row %0d got row=%0d data=%h cur=%h required row=%0d data=%h cur=%h",
                             s, rr, o_row, o_wdat, o_cur, rr, W'(en[rr]), W'(ec[rr]));
                end
            end
            if (n == last) begin
                model_commit(s, rows);
                checks++;
                if (o_tap !== W'(mt[s])) begin errors++; $display("FAIL tap_u dut%0d got %h required %h", s, o_tap, W'(mt[s])); end
            end
            if (n == glitch_at) set_ctl(s, 1'b1, 1'b1, 2, 'h15555);
            if (n == abort_at) begin
                reset = 1'b1;
                @(negedge clk_50);
                reset = 1'b0;
                sample(s);
                checks++;
                if (o_busy !== 1'b0 || o_done !== 1'b0 || o_wv !== 1'b0 || o_tap !== '0 || o_cur !== '0) begin
                    errors++;
                    $display("FAIL abort dut%0d got busy=%b done=%b wv=%b tap=%h cur=%h required all 0",
                             s, o_busy, o_done, o_wv, o_tap, o_cur);
                end
                model_commit(s, abort_at / 4);
                mb[0] = 0; mb[1] = 0; mt[0] = 0; mt[1] = 0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_50);
        for (int s = 0; s < 2; s++) begin
            sample(s);
            checks++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_wv !== 1'b0) begin
                errors++; $display("FAIL reset_flags dut%0d busy=%b done=%b wv=%b required 0", s, o_busy, o_done, o_wv);
            end
            checks++;
            if (o_tap !== '0 || o_cur !== '0 || o_wdat !== '0 || o_row !== 0) begin
                errors++; $display("FAIL reset_values dut%0d tap=%h cur=%h data=%h row=%0d required 0", s, o_tap, o_cur, o_wdat, o_row);
            end
            mb[s] = 0; mt[s] = 0;
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_field();
        for (int i = 0; i < 30; i++) vbuf[i] = 0;
        load_column(0);
        run_step(0, 'h08000, 0, 0, -1, -1);
    endtask

    task automatic test_impulse();
        for (int i = 0; i < 30; i++) vbuf[i] = 0;
        vbuf[5] = 'h08000;
        vbuf[15] = 'h08000;
        load_column(0);
        run_step(0, 'h08000, 0, 0, -1, -1);
        run_step(0, 'h08000, 0, 0, -1, -1);
    endtask

    task automatic test_init_priority();
        @(negedge clk_50);
        set_ctl(0, 1'b1, 1'b1, 7, 'h01234);
        mc[0][7] = 'h01234; mp[0][7] = 'h01234;
        @(negedge clk_50);
        set_ctl(0, 1'b0, 1'b0, 0, 0);
        sample(0);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL init_priority busy=%b required 0", o_busy); end
        run_step(0, rnd_val(), rnd_val(), rnd_val(), -1, -1);
    endtask

    task automatic test_random(input int s, input int nsteps);
        for (int i = 0; i < 30; i++) vbuf[i] = rnd_val();
        load_column(s);
        for (int k = 0; k < nsteps; k++) run_step(s, rnd_val(), rnd_val(), rnd_val(), -1, -1);
    endtask

    task automatic test_glitch();
        run_step(0, rnd_val(), rnd_val(), rnd_val(), 37, -1);
        run_step(0, rnd_val(), 0, 0, -1, -1);
    endtask

    task automatic test_abort();
        run_step(0, rnd_val(), rnd_val(), rnd_val(), -1, 50);
        run_step(0, rnd_val(), rnd_val(), rnd_val(), -1, -1);
        run_step(1, rnd_val(), rnd_val(), rnd_val(), -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) run_step(0, rnd_val(), 0, 0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_zero_field();
        test_impulse();
        test_init_priority();
        test_random(0, 2);
        test_random(1, 6);
        test_random(1, 6);
        test_glitch();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/drum_column_engine.md
# drum_column_engine

Parametrised single-column engine for the finite-difference drum-membrane simulation. It holds one column of ROWS nodes in two block RAMs: current and previous displacement. On each time step it walks the column bottom-to-top, computing one node's next value per row-slot. A top level instantiates COLS copies in lockstep, wiring each engine's centre value to its neighbours' left/right inputs. It generalises the fixed 30×18-bit column with configurable rows, width, damping shifts, tap row and optional saturation. It also adds a host load port and a per-row writeback observation port.

## Interface
- W, 18: sample width, signed fixed point 1.(W-1)
- ROWS, 30: nodes per column, 2..2^AW
- AW, 5: row address width
- TAP_ROW, 15: row reported on tap_u
- PREV_SHIFT, 10: prev-term leak shift
- DAMP_SHIFT, 9: output damping shift
- SATURATE, 0: 0 = two's-complement wrap, 1 = clamp to [-2^(W-1), 2^(W-1)-1]
- clk_50 in 1: single clock, all logic on rising edge
- reset in 1: synchronous, active-high
- init_we in 1: host write strobe, load mode
- init_addr in AW: row to load
- init_data in W: value written to both curr and prev RAM
- step_start in 1: start one time step
- rho_eff in W: coupling coefficient, held stable during step
- left_u, right_u in W: neighbour column centre values; edge columns tie to 0
- cur_u out W: this column's centre value for the current row-slot
- busy out 1: high whenever state ≠ IDLE
- step_done out 1: one-cycle pulse at step completion; tap_u valid from the same cycle
- tap_u out W: pre-update value of TAP_ROW from the last completed step
- wr_valid out 1: pulse when a row's next value is written
- wr_row out AW / wr_data out W: row and value written

## Operation
- States: IDLE, RD, WT, LD, WR, DONE.
- IDLE
  - init_we writes curr[init_addr] and prev[init_addr]; addr ≥ ROWS is ignored.
  - A write to row 0 also loads bottom_reg.
  - step_start with init_we low → RD, row = 0.
  - step_start with init_we high in the same cycle: the init write wins and step_start is ignored.
- RD: read curr[row+1] if row < ROWS-1; read prev[row].
- WT: RAM latency cycle.
- LD: up = (row == ROWS-1) ? 0 : q_curr; prv = q_prev.
- WR
  - center = (row == 0) ? bottom_reg : center_reg; down = (row == 0) ? 0 : down_reg.
  - Write curr[row] = next and prev[row] = center; pulse wr_valid.
  - If row == 0, bottom_reg ← next. If row == TAP_ROW, capture center for tap.
  - If row < ROWS-1: down_reg ← center, center_reg ← up, row++, → RD. Otherwise → DONE.
- DONE: tap_u ← captured value, step_done = 1, → IDLE.
- cur_u = center during all states. Lockstep engines therefore see each other's centre for the same row.
- Arithmetic, all W-bit
  - sum = left + right + up + down − 4·center
  - m = signed_mult(sum, rho_eff), i.e. bits {p[2W-1], p[2W-3:W-1]} of the 2W product
  - inter = m + (center <<< 1) − prv + (prv >>> PREV_SHIFT)
  - next = inter − (inter >>> DAMP_SHIFT)
  - SATURATE=0: intermediates wrap mod 2^W.
  - SATURATE=1: inter and next are computed at W+3 bits and clamped.
- step_start and init_we while busy are ignored.
- Reset
  - Outputs after reset: busy 0, step_done 0, wr_valid 0, tap_u 0, cur_u 0, wr_row 0, wr_data 0.
  - bottom_reg, center_reg and down_reg clear to 0. RAM contents are not cleared; the host reloads.
  - Reset mid-step aborts immediately to IDLE; rows already written stay written.

## Timing
- step_start sampled at edge T → RD in cycle T+1; each row takes exactly 4 cycles (RD, WT, LD, WR).
- wr_valid for row r is high in cycle T+4r+4.
- step_done is high in cycle T+4·ROWS+1 (121 for ROWS=30); busy spans T+1 through that cycle.
- Earliest next step_start: the cycle after step_done.
- RAMs: one write and one read port each, registered read, one-cycle latency, read-during-write returns old data.
- init writes take effect at the next edge; back-to-back writes are allowed.

## Test plan
- Zero field, rho_eff=0x08000 (0.25), neighbours 0, step → all wr_data 0; step_done exactly 4·ROWS+1 cycles after step_start; tap_u 0.
- Impulse: load row 5 curr=prev=0x08000, others 0, rho 0.25 → row 5 next 0x00020; rows 4 and 6 next 0x01FF0; all other rows 0.
- Two steps from the impulse with TAP_ROW=5 → tap_u 0x08000 after step 1, 0x00020 after step 2.
- SATURATE=1: load row 3 center 0x1FFFF, prev 0x20000, rho 0 → wr_data 0x1FFFF, not wrapped. SATURATE=0, same load → wrapped value.
- step_start and init_we pulsed mid-step → ignored, latency unchanged, RAM unaffected. Boundaries: row 0 uses down=0, row ROWS-1 uses up=0; ROWS=4 build passes.
- Reset asserted at cycle T+50 → busy 0 next cycle, no step_done. Rows 0..11 rewritten, rest unchanged via a subsequent step's wr_data.
